fetch_sequencer: RTL and testbench



---
 rtl/fetch_sequencer.sv | 104 ++++++++++
 tb/tb_fetch_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / program-sequencing stage: owns the PC, picks the next address
// from decoder Halt/Branch and the ALU zero flag, and keeps per-run statistics.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | after reset, PC parked at START_ADDR, waiting for Start
// S_RUN    | one instruction per cycle, PC advances or branches
// S_HALTED | halt seen, PC and counters frozen, Start restarts the program
module fetch_sequencer #(
   parameter int              PC_W       = 10,
   parameter logic [PC_W-1:0] START_ADDR = '0,
   parameter int              CNT_W      = 16
) (
   input  logic             CLK,
   input  logic             reset_n,
   input  logic             Start,
   input  logic             Halt,
   input  logic             Branch,
   input  logic             Zero,
   input  logic [6:0]       BranchOffset,
   output logic [PC_W-1:0]  InstrAddr,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] CycleCount,
   output logic [CNT_W-1:0] TakenCount
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   localparam logic [PC_W-1:0]  PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic             running_q, running_d;
   logic             done_q, done_d;

   logic [PC_W+6:0]  off_ext;
   logic [CNT_W-1:0] cycle_inc;
   logic [CNT_W-1:0] taken_inc;

   // Extend past PC_W so the low PC_W bits are correct even when PC_W < 7.
   assign off_ext   = {{PC_W{BranchOffset[6]}}, BranchOffset};
   assign cycle_inc = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
   assign taken_inc = (&taken_cnt_q) ? taken_cnt_q : taken_cnt_q + CNT_ONE;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      cycle_cnt_d = cycle_cnt_q;
      taken_cnt_d = taken_cnt_q;
      case (state_q)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               state_d     = S_RUN;
               pc_d        = START_ADDR;
               cycle_cnt_d = '0;
               taken_cnt_d = '0;
            end
         end
         S_RUN: begin
            cycle_cnt_d = cycle_inc;
            if (Halt) begin
               state_d = S_HALTED;
            end else if (Branch && Zero) begin
               pc_d        = pc_q + off_ext[PC_W-1:0];
               taken_cnt_d = taken_inc;
            end else begin
               pc_d = pc_q + PC_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      running_d = (state_d == S_RUN);
      done_d    = (state_d == S_HALTED);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         pc_q        <= START_ADDR;
         cycle_cnt_q <= '0;
         taken_cnt_q <= '0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         cycle_cnt_q <= cycle_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         running_q   <= running_d;
         done_q      <= done_d;
      end
   end

   assign InstrAddr  = pc_q;
   assign Running    = running_q;
   assign Done       = done_q;
   assign CycleCount = cycle_cnt_q;
   assign TakenCount = taken_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: default build plus a 4-bit PC build for
// wrap checks and a 3-bit counter build for saturation checks.
module tb_fetch_sequencer;

   logic       CLK = 1'b0;
   logic       reset_n;
   logic       Start, Halt, Branch, Zero;
   logic [6:0] BranchOffset;

   logic [9:0]  addr_a;
   logic        run_a, done_a;
   logic [15:0] cyc_a, tkn_a;

   logic [3:0]  addr_b;
   logic        run_b, done_b;
   logic [15:0] cyc_b, tkn_b;

   logic [9:0]  addr_c;
   logic        run_c, done_c;
   logic [2:0]  cyc_c, tkn_c;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   fetch_sequencer u_dut (
      .CLK(CLK), .reset_n(reset_n), .Start(Start), .Halt(Halt), .Branch(Branch),
      .Zero(Zero), .BranchOffset(BranchOffset), .InstrAddr(addr_a), .Running(run_a),
      .Done(done_a), .CycleCount(cyc_a), .TakenCount(tkn_a)
   );

   fetch_sequencer #(.PC_W(4)) u_dut_pc4 (
      .CLK(CLK), .reset_n(reset_n), .Start(Start), .Halt(Halt), .Branch(Branch),
      .Zero(Zero), .BranchOffset(BranchOffset), .InstrAddr(addr_b), .Running(run_b),
      .Done(done_b), .CycleCount(cyc_b), .TakenCount(tkn_b)
   );

   fetch_sequencer #(.CNT_W(3)) u_dut_cnt3 (
      .CLK(CLK), .reset_n(reset_n), .Start(Start), .Halt(Halt), .Branch(Branch),
      .Zero(Zero), .BranchOffset(BranchOffset), .InstrAddr(addr_c), .Running(run_c),
      .Done(done_c), .CycleCount(cyc_c), .TakenCount(tkn_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic restart();
      Start = 1'b1;
      step();
      Start = 1'b0;
   endtask

   task automatic clear_in();
      Halt = 1'b0; Branch = 1'b0; Zero = 1'b0; BranchOffset = 7'd0;
   endtask

   task automatic halt_now();
      Halt = 1'b1;
      step();
      Halt = 1'b0;
   endtask

   initial begin
      int seq3 [7];
      seq3 = '{0, 1, 2, 3, 0, 1, 2};
      reset_n = 1'b0; Start = 1'b0;
      clear_in();
      #12;
      chk("rst_addr", addr_a, 0);
      chk("rst_running", run_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cycles", cyc_a, 0);
      chk("rst_taken", tkn_a, 0);
      reset_n = 1'b1;

      // idle, no start
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_addr", addr_a, 0);
         chk("idle_running", run_a, 0);
         chk("idle_done", done_a, 0);
         chk("idle_cycles", cyc_a, 0);
      end

      // straight-line run to halt at 5
      restart();
      chk("start_running", run_a, 1);
      chk("start_addr", addr_a, 0);
      for (int i = 0; i < 6; i++) begin
         chk("seq_addr", addr_a, i);
         if (i == 5) Halt = 1'b1;
         step();
      end
      Halt = 1'b0;
      chk("halt_done", done_a, 1);
      chk("halt_running", run_a, 0);
      chk("halt_addr", addr_a, 5);
      chk("halt_cycles", cyc_a, 6);
      chk("halt_taken", tkn_a, 0);
      step();
      chk("halted_hold_addr", addr_a, 5);
      chk("halted_hold_cycles", cyc_a, 6);

      // backward branch -3 at address 3, halt at 2
      restart();
      chk("restart_cycles", cyc_a, 0);
      chk("restart_done", done_a, 0);
      for (int i = 0; i < 7; i++) begin
         chk("br_seq_addr", addr_a, seq3[i]);
         if (i == 3) begin Branch = 1'b1; Zero = 1'b1; BranchOffset = 7'h7D; end
         else clear_in();
         if (i == 6) Halt = 1'b1;
         step();
      end
      clear_in();
      chk("br_done", done_a, 1);
      chk("br_addr", addr_a, 2);
      chk("br_taken", tkn_a, 1);
      chk("br_cycles", cyc_a, 7);

      // negative offset wrapping below zero, then PC wrap at top
      restart();
      step();
      Branch = 1'b1; Zero = 1'b1; BranchOffset = 7'h7D;
      step();
      clear_in();
      chk("negwrap_addr", addr_a, 1022);
      step();
      chk("top_addr", addr_a, 1023);
      step();
      chk("wrap_addr", addr_a, 0);
      halt_now();
      chk("negwrap_taken", tkn_a, 1);
      chk("negwrap_cycles", cyc_a, 5);

      // branch not taken when Zero=0
      restart();
      repeat (3) step();
      Branch = 1'b1; Zero = 1'b0; BranchOffset = 7'd10;
      step();
      clear_in();
      chk("nt_addr", addr_a, 4);
      chk("nt_taken", tkn_a, 0);
      halt_now();

      // halt beats a taken branch
      restart();
      repeat (3) step();
      Branch = 1'b1; Zero = 1'b1; BranchOffset = 7'd10; Halt = 1'b1;
      step();
      clear_in();
      chk("hpri_done", done_a, 1);
      chk("hpri_addr", addr_a, 3);
      chk("hpri_taken", tkn_a, 0);
      chk("hpri_cycles", cyc_a, 4);

      // zero-offset spin loop; 3-bit counters saturate at 7
      restart();
      Branch = 1'b1; Zero = 1'b1; BranchOffset = 7'd0;
      repeat (9) step();
      chk("spin_addr", addr_a, 0);
      chk("spin_taken", tkn_a, 9);
      chk("sat_taken", tkn_c, 7);
      chk("sat_cycles", cyc_c, 7);
      halt_now();
      clear_in();
      chk("spin_done", done_a, 1);
      chk("spin_cycles", cyc_a, 10);
      chk("sat_cycles_halt", cyc_c, 7);
      chk("sat_taken_halt", tkn_c, 7);

      // 4-bit PC wrap and Start ignored while running
      restart();
      repeat (14) step();
      chk("pc4_addr14", addr_b, 14);
      Start = 1'b1;
      step();
      Start = 1'b0;
      chk("pc4_addr15", addr_b, 15);
      chk("pc4_running", run_b, 1);
      chk("ign_start_addr", addr_a, 15);
      chk("ign_start_cycles", cyc_a, 15);
      step();
      chk("pc4_wrap", addr_b, 0);
      chk("pc4_cycles", cyc_b, 16);
      halt_now();

      // async reset mid-run
      restart();
      repeat (7) step();
      chk("pre_rst_addr", addr_a, 7);
      #2 reset_n = 1'b0;
      #1;
      chk("async_addr", addr_a, 0);
      chk("async_running", run_a, 0);
      chk("async_done", done_a, 0);
      chk("async_cycles", cyc_a, 0);
      reset_n = 1'b1;
      step();
      chk("post_rst_idle", run_a, 0);
      chk("post_rst_addr", addr_a, 0);

      // restart from HALTED clears counters
      restart();
      chk("run2_running", run_a, 1);
      repeat (3) step();
      halt_now();
      chk("run2_done", done_a, 1);
      chk("run2_addr", addr_a, 3);
      chk("run2_cycles", cyc_a, 4);
      restart();
      chk("rs_addr", addr_a, 0);
      chk("rs_cycles", cyc_a, 0);
      chk("rs_taken", tkn_a, 0);
      chk("rs_done", done_a, 0);
      chk("rs_running", run_a, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
